// File: rtl/fifo_dot_mac_pkg.sv
// Shared types and default widths for the FIFO-fed dot-product engine.
package dot_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } dot_state_t;

  localparam int DOT_DATA_W = 8;
  localparam int DOT_ACC_W  = 24;
  localparam int DOT_LEN    = 8;

endpackage

// File: rtl/fifo_dot_mac_mac_unit.sv
// Registered unsigned multiply-accumulate with synchronous clear.
// acc_next exposes acc plus the current product, so the caller can capture the final sum on the same edge.
module mac_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc,
  output logic [ACC_WIDTH-1:0]  acc_next
);

  logic [2*DATA_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0]    prod_ext;

  // The product is zero-extended or truncated to the accumulator width; the sum wraps.
  assign prod     = a * b;
  assign prod_ext = ACC_WIDTH'(prod);
  assign acc_next = acc + prod_ext;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/fifo_dot_mac.sv
// Drains paired A/B FIFOs for LEN element pairs and reports their unsigned dot product.
// FIFO read data arrives one cycle after the pop, so pops and accumulates are offset by rd_vld.
module fifo_dot_mac
  import dot_pkg::*;
#(
  parameter int DATA_WIDTH = DOT_DATA_W,
  parameter int ACC_WIDTH  = DOT_ACC_W,
  parameter int LEN        = DOT_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  a_empty,
  input  logic                  b_empty,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  a_rden,
  output logic                  b_rden,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  done,
  output logic                  busy
);

  localparam int CW = $clog2(LEN + 1);
  localparam logic [CW-1:0] LEN_C  = CW'(LEN);
  localparam logic [CW-1:0] LAST_C = CW'(LEN - 1);

  dot_state_t           state;
  logic [CW-1:0]        issued;
  logic [CW-1:0]        recvd;
  logic                 rd_vld;
  logic                 issue;
  logic                 clr;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_next;

  // Both FIFOs are always popped together, and never while reset is held.
  assign issue  = !rst && (state == RUN) && !a_empty && !b_empty && (issued < LEN_C);
  assign a_rden = issue;
  assign b_rden = issue;
  assign clr    = (state == IDLE) && start;

  mac_unit #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .en      (rd_vld),
    .a       (a_data),
    .b       (b_data),
    .acc     (acc),
    .acc_next(acc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      issued <= '0;
      recvd  <= '0;
      rd_vld <= 1'b0;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      done   <= 1'b0;
      rd_vld <= issue;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            issued <= '0;
            recvd  <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (issue) begin
            issued <= issued + CW'(1);
          end
          // The last accumulate publishes the sum directly rather than waiting a cycle for acc.
          if (rd_vld) begin
            recvd <= recvd + CW'(1);
            if (recvd == LAST_C) begin
              result <= acc_next;
              done   <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_dot_mac.md
Name: fifo_dot_mac

Overview:
- Downstream consumer of a pair of synchronous FIFOs: operand A stream and operand B stream.
- On `start`, pops exactly LEN element pairs (one from each FIFO), multiplies each pair unsigned and accumulates the products.
- Presents the dot product on `result` with a one-cycle `done` pulse.
- This is the compute stage that drains the matrix-row and vector FIFOs.

Parameters:
- DATA_WIDTH, 8, width of each FIFO element (unsigned)
- ACC_WIDTH, 24, accumulator/result width; arithmetic is modulo 2^ACC_WIDTH
- LEN, 8, element pairs per dot product (>=1)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request one dot product; sampled only in IDLE
- a_empty  input  1  empty flag of A FIFO
- b_empty  input  1  empty flag of B FIFO
- a_data  input  DATA_WIDTH  A FIFO registered read data
- b_data  input  DATA_WIDTH  B FIFO registered read data
- a_rden  output  1  pop A FIFO
- b_rden  output  1  pop B FIFO
- result  output  ACC_WIDTH  last completed dot product, held until next completion
- done  output  1  one-cycle pulse when `result` updates
- busy  output  1  high in RUN and DONE

Behaviour:
- Clocking and reset:
  - Single clock `clk`.
  - `rst` is synchronous, active-high, and has priority over everything.
  - Reset values: state=IDLE, acc=0, result=0, done=0, busy=0, issue/recv counters=0, rd_vld=0.
  - `a_rden` and `b_rden` are 0 while `rst` is high.
- FIFO contract: data for a pop issued in cycle N appears on a_data/b_data after the next rising edge and is consumed in cycle N+1.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0.
  - start=1 → acc<=0, issued<=0, recvd<=0, go to RUN.
- RUN:
  - Issue condition (combinational): issue = !a_empty & !b_empty & (issued<LEN).
  - a_rden = b_rden = issue. The two pops are always simultaneous, never one without the other.
  - On issue, issued increments.
  - rd_vld <= issue (one-cycle valid pipeline).
  - When rd_vld=1: acc <= acc + a_data*b_data, and recvd increments.
  - Product is 2*DATA_WIDTH bits, zero-extended or truncated to ACC_WIDTH. Overflow wraps with no flag.
  - On the accumulate where recvd reaches LEN: result <= acc+product, go to DONE.
- DONE:
  - done=1 for exactly this one cycle; busy=1; no pops.
  - Next state IDLE unconditionally.
- start is ignored in RUN and DONE; it is not queued.
- Stalls:
  - Either FIFO empty → no pop that cycle, and the counters hold.
  - Partial stalls of any length are tolerated; the result is independent of stall pattern.
- Latency (FIFOs never empty): start sampled at edge 0; pops at edges 1..LEN; accumulates at edges 2..LEN+1; done high in the cycle after edge LEN+1.
  - Total LEN+2 cycles from start to done, inclusive of the DONE cycle.
- No pop is ever issued in IDLE, or after LEN pops in the current operation.
- Reset mid-RUN:
  - Operation is abandoned and `result` returns to 0.
  - Any FIFO data already popped is lost. The upstream is responsible for re-priming.
- Counter widths: $clog2(LEN+1) bits.

Decomposition:
- Shared package `dot_pkg`:
  - state enum typedef `dot_state_t` {IDLE, RUN, DONE}.
  - default width constants DOT_DATA_W=8, DOT_ACC_W=24, DOT_LEN=8.
- One natural sub-module `mac_unit`: registered multiply-accumulate with clr (sync), en, a, b, acc out.
- FSM and pop control stay in the top.

Test Plan:
1. FIFOs pre-loaded A=1..8, B=2 each, pulse start → a_rden/b_rden high 8 consecutive cycles, done at start+10 (LEN+2 cycles inclusive), result=72 (0x48), busy low after done.
2. A=B=255 ×8 → result=520200 (0x07F008). Then ACC_WIDTH=16 build → result=520200 mod 65536=0xF008.
3. B FIFO empty for first 5 cycles of RUN, then filled with 3s; A=1..8 → no rden while b_empty, exactly 8 pops total, result=108.
4. start held high through RUN and DONE → one operation only. Second operation begins only from IDLE; result identical to single-start run.
5. rst pulsed at 4th pop → next cycle busy=0, done=0, result=0, rden=0. New start with refilled FIFOs yields correct result.
6. Two back-to-back operations (A=1..8/B=1 then A=1..8/B=2) → results 36 then 72, accumulator cleared between them, result holds 36 until the second done.
